// File: rtl/datapath_seq_pkg.sv
// Shared types and constants for the datapath micro-sequencer.
package datapath_seq_pkg;

  localparam int P_N  = 4;
  localparam int P_AW = 2;
  localparam int P_CW = 4;

  typedef enum logic [1:0] {
    CMD_LOADI = 2'd0,
    CMD_ALU   = 2'd1,
    CMD_REP   = 2'd2,
    CMD_NOP   = 2'd3
  } t_cmd_kind;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_REP  = 2'd2,
    S_DONE = 2'd3
  } t_seq_state;

  typedef struct packed {
    logic sign;
    logic zero;
    logic overflow;
    logic carryOut;
  } t_flag;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;

  typedef struct packed {
    t_cmd_kind         kind;
    logic [3:0]        op;
    logic [P_AW-1:0]   rd;
    logic [P_AW-1:0]   rs1;
    logic [P_AW-1:0]   rs2;
    logic [P_N-1:0]    imm;
    logic [P_CW-1:0]   cnt;
  } t_cmd;

  // A REP run ends after the write of the cycle holding iter==1, or early on abort.
  function automatic logic is_last_iter(input logic [P_CW-1:0] iter, input logic abort);
    return (iter == P_CW'(1)) || abort;
  endfunction

endpackage

// File: rtl/datapath_seq_if.sv
// Command handshake bus between a command source and the sequencer.
interface datapath_seq_if;
  import datapath_seq_pkg::*;

  logic              iCmdValid;
  logic              oCmdReady;
  logic [1:0]        iCmdKind;
  logic [3:0]        iCmdOp;
  logic [P_AW-1:0]   iCmdRd;
  logic [P_AW-1:0]   iCmdRs1;
  logic [P_AW-1:0]   iCmdRs2;
  logic [P_N-1:0]    iCmdImm;
  logic [P_CW-1:0]   iCmdCnt;

  modport master (
    output iCmdValid, iCmdKind, iCmdOp, iCmdRd, iCmdRs1, iCmdRs2, iCmdImm, iCmdCnt,
    input  oCmdReady
  );

  modport slave (
    input  iCmdValid, iCmdKind, iCmdOp, iCmdRd, iCmdRs1, iCmdRs2, iCmdImm, iCmdCnt,
    output oCmdReady
  );

endinterface

// File: rtl/datapath_seq_ctrl_decode.sv
// Moore decode of sequencer state plus latched command into regfile/ALU controls.
module seq_ctrl_decode
  import datapath_seq_pkg::*;
(
  input  t_seq_state       i_state,
  input  t_cmd_kind        i_kind,
  input  logic [3:0]       i_op,
  input  logic [P_AW-1:0]  i_rd,
  input  logic [P_AW-1:0]  i_rs1,
  input  logic [P_AW-1:0]  i_rs2,
  input  logic [P_N-1:0]   i_imm,
  output logic             o_we,
  output logic [P_AW-1:0]  o_wa,
  output logic [P_AW-1:0]  o_ra1,
  output logic [P_AW-1:0]  o_ra2,
  output logic             o_ysel,
  output logic [P_N-1:0]   o_imm,
  output logic [3:0]       o_aluop
);

  // Everything idles at zero; only EXEC (LOADI/ALU) and REP drive a write.
  always_comb begin
    o_we    = 1'b0;
    o_wa    = '0;
    o_ra1   = '0;
    o_ra2   = '0;
    o_ysel  = 1'b0;
    o_imm   = '0;
    o_aluop = '0;
    case (i_state)
      S_EXEC: begin
        case (i_kind)
          CMD_LOADI: begin
            o_we   = 1'b1;
            o_wa   = i_rd;
            o_ysel = 1'b1;
            o_imm  = i_imm;
          end
          CMD_ALU: begin
            o_we    = 1'b1;
            o_wa    = i_rd;
            o_ra1   = i_rs1;
            o_ra2   = i_rs2;
            o_aluop = i_op;
          end
          default: ;
        endcase
      end
      S_REP: begin
        o_we    = 1'b1;
        o_wa    = i_rd;
        o_ra1   = i_rd;
        o_ra2   = i_rs2;
        o_aluop = i_op;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/datapath_seq.sv
// Command-driven micro-sequencer for the register file + ALU datapath.
module datapath_seq
  import datapath_seq_pkg::*;
#(
  parameter int N  = P_N,
  parameter int AW = P_AW,
  parameter int CW = P_CW
) (
  input  logic           Clk,
  input  logic           Rst_n,
  datapath_seq_if.slave  bus,
  input  logic           iAbort,
  input  logic [3:0]     iFlag,
  output logic           oWE,
  output logic [AW-1:0]  oWA,
  output logic [AW-1:0]  oRA1,
  output logic [AW-1:0]  oRA2,
  output logic           oYSel,
  output logic [N-1:0]   oImm,
  output logic [3:0]     oALUop,
  output logic [3:0]     oFlag,
  output logic           oBusy,
  output logic           oDone
);

  t_seq_state      r_state;
  t_cmd            r_cmd;
  logic [CW-1:0]   r_iter;
  t_flag           r_flag;

  // Sequencer FSM: captures a command in IDLE, runs it, then pulses DONE for a cycle.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
      r_cmd   <= '0;
      r_iter  <= '0;
      r_flag  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.iCmdValid) begin
            r_cmd <= '{kind: t_cmd_kind'(bus.iCmdKind),
                       op:   bus.iCmdOp,
                       rd:   bus.iCmdRd,
                       rs1:  bus.iCmdRs1,
                       rs2:  bus.iCmdRs2,
                       imm:  bus.iCmdImm,
                       cnt:  bus.iCmdCnt};
            r_iter  <= bus.iCmdCnt;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (r_cmd.kind)
            CMD_ALU: begin
              r_flag  <= t_flag'(iFlag);
              r_state <= S_DONE;
            end
            CMD_REP: r_state <= (r_cmd.cnt == '0) ? S_DONE : S_REP;
            default: r_state <= S_DONE;
          endcase
        end
        S_REP: begin
          r_iter <= r_iter - CW'(1);
          r_flag <= t_flag'(iFlag);
          if (is_last_iter(r_iter, iAbort)) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.oCmdReady = (r_state == S_IDLE);
  assign oBusy         = (r_state != S_IDLE);
  assign oDone         = (r_state == S_DONE);
  assign oFlag         = r_flag;

  seq_ctrl_decode u_decode (
    .i_state (r_state),
    .i_kind  (r_cmd.kind),
    .i_op    (r_cmd.op),
    .i_rd    (r_cmd.rd),
    .i_rs1   (r_cmd.rs1),
    .i_rs2   (r_cmd.rs2),
    .i_imm   (r_cmd.imm),
    .o_we    (oWE),
    .o_wa    (oWA),
    .o_ra1   (oRA1),
    .o_ra2   (oRA2),
    .o_ysel  (oYSel),
    .o_imm   (oImm),
    .o_aluop (oALUop)
  );

endmodule

// File: tb/tb_datapath_seq.sv
// Directed bench: sequencer driving a behavioural 4x4 register file and ALU.
module tb_datapath_seq;
  import datapath_seq_pkg::*;

  logic       Clk;
  logic       Rst_n;
  logic       iAbort;
  logic [3:0] iFlag;
  logic       oWE;
  logic [1:0] oWA, oRA1, oRA2;
  logic       oYSel;
  logic [3:0] oImm, oALUop, oFlag;
  logic       oBusy, oDone;

  datapath_seq_if bus ();

  datapath_seq #(.N(4), .AW(2), .CW(4)) dut (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .bus    (bus),
    .iAbort (iAbort),
    .iFlag  (iFlag),
    .oWE    (oWE),
    .oWA    (oWA),
    .oRA1   (oRA1),
    .oRA2   (oRA2),
    .oYSel  (oYSel),
    .oImm   (oImm),
    .oALUop (oALUop),
    .oFlag  (oFlag),
    .oBusy  (oBusy),
    .oDone  (oDone)
  );

  int checks = 0;
  int failures = 0;

  // Clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Behavioural ALU: returns {sign, zero, overflow, carryOut, y}
  function automatic logic [7:0] aluModel(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] y;
    logic c, v;
    s = '0; c = 1'b0; v = 1'b0;
    case (op)
      ALU_ADD: begin s = {1'b0, a} + {1'b0, b}; y = s[3:0]; c = s[4]; v = (a[3] == b[3]) && (y[3] != a[3]); end
      ALU_SUB: begin s = {1'b0, a} - {1'b0, b}; y = s[3:0]; c = s[4]; v = (a[3] != b[3]) && (y[3] != a[3]); end
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      default: y = a;
    endcase
    return {y[3], (y == 4'h0), v, c, y};
  endfunction

  // Register file and write-data mux around the DUT
  logic [3:0] rf [4];
  logic [7:0] aluOut;
  logic [3:0] wData;
  int wrCount = 0;

  always_comb begin
    aluOut = aluModel(oALUop, rf[oRA1], rf[oRA2]);
    iFlag  = aluOut[7:4];
    wData  = oYSel ? oImm : aluOut[3:0];
  end

  always @(posedge Clk) begin
    if (oWE) begin
      rf[oWA] <= wData;
      wrCount <= wrCount + 1;
    end
  end

  // Results captured by applyStimulus
  int         lat;
  int         nWrites;
  logic       sWE, sYSel, sReady, sBusy, sDoneAfter;
  logic [1:0] sWA;
  logic [3:0] sImm;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Issue one command, follow it to oDone, record latency/first-cycle controls/write count.
  task automatic applyStimulus(input logic [1:0] kind, input logic [3:0] op,
                               input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2,
                               input logic [3:0] imm, input logic [3:0] cnt, input int abortAt);
    int guard;
    int wrBefore;
    logic doneSeen;
    @(negedge Clk);
    bus.iCmdValid = 1'b1;
    bus.iCmdKind  = kind;
    bus.iCmdOp    = op;
    bus.iCmdRd    = rd;
    bus.iCmdRs1   = rs1;
    bus.iCmdRs2   = rs2;
    bus.iCmdImm   = imm;
    bus.iCmdCnt   = cnt;
    guard = 0;
    while (!bus.oCmdReady && guard < 20) begin
      @(negedge Clk);
      guard++;
    end
    checkOutput("readyBeforeAccept", 16'(bus.oCmdReady), 16'h1);
    wrBefore = wrCount;
    @(posedge Clk);
    lat = 1;
    doneSeen = 1'b0;
    while (!doneSeen && lat < 40) begin
      @(negedge Clk);
      if (lat == 1) begin
        sWE = oWE; sWA = oWA; sYSel = oYSel; sImm = oImm;
        sReady = bus.oCmdReady; sBusy = oBusy;
        bus.iCmdKind = CMD_LOADI;
        bus.iCmdRd   = 2'd0;
        bus.iCmdImm  = 4'hF;
        bus.iCmdCnt  = 4'h0;
      end else begin
        bus.iCmdValid = 1'b0;
      end
      iAbort = (abortAt != 0) && (lat == abortAt + 1);
      if (oDone) doneSeen = 1'b1;
      else begin
        @(posedge Clk);
        lat++;
      end
    end
    iAbort = 1'b0;
    bus.iCmdValid = 1'b0;
    checkOutput("doneSeen", 16'(doneSeen), 16'h1);
    nWrites = wrCount - wrBefore;
    @(negedge Clk);
    sDoneAfter = oDone;
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Rst_n = 1'b0;
    iAbort = 1'b0;
    bus.iCmdValid = 1'b0;
    bus.iCmdKind = '0; bus.iCmdOp = '0; bus.iCmdRd = '0;
    bus.iCmdRs1 = '0; bus.iCmdRs2 = '0; bus.iCmdImm = '0; bus.iCmdCnt = '0;

    // Reset state
    repeat (2) @(negedge Clk);
    checkOutput("rstWE", 16'(oWE), 16'h0);
    checkOutput("rstBusy", 16'(oBusy), 16'h0);
    checkOutput("rstDone", 16'(oDone), 16'h0);
    checkOutput("rstFlag", 16'(oFlag), 16'h0);
    Rst_n = 1'b1;
    #1 checkOutput("rstReady", 16'(bus.oCmdReady), 16'h1);

    // LOADI R1=3
    applyStimulus(CMD_LOADI, ALU_ADD, 2'd1, 2'd0, 2'd0, 4'h3, 4'h0, 0);
    checkOutput("loadiWE", 16'(sWE), 16'h1);
    checkOutput("loadiWA", 16'(sWA), 16'h1);
    checkOutput("loadiYSel", 16'(sYSel), 16'h1);
    checkOutput("loadiImm", 16'(sImm), 16'h3);
    checkOutput("loadiReadyBusy", 16'(sReady), 16'h0);
    checkOutput("loadiBusy", 16'(sBusy), 16'h1);
    checkOutput("loadiWrites", 16'(nWrites), 16'h1);
    checkOutput("loadiLat", 16'(lat), 16'h2);
    checkOutput("loadiDonePulse", 16'(sDoneAfter), 16'h0);
    checkOutput("loadiR1", 16'(rf[1]), 16'h3);
    checkOutput("loadiFlag", 16'(oFlag), 16'h0);

    // LOADI R0=0, LOADI R2=9, ALU ADD R3 = R2 + R2
    applyStimulus(CMD_LOADI, ALU_ADD, 2'd0, 2'd0, 2'd0, 4'h0, 4'h0, 0);
    applyStimulus(CMD_LOADI, ALU_ADD, 2'd2, 2'd0, 2'd0, 4'h9, 4'h0, 0);
    applyStimulus(CMD_ALU, ALU_ADD, 2'd3, 2'd2, 2'd2, 4'h0, 4'h0, 0);
    checkOutput("aluYSel", 16'(sYSel), 16'h0);
    checkOutput("aluWrites", 16'(nWrites), 16'h1);
    checkOutput("aluLat", 16'(lat), 16'h2);
    checkOutput("aluR3", 16'(rf[3]), 16'h2);
    checkOutput("aluFlag", 16'(oFlag), 16'h3);

    // LOADI R1=3, REP ADD Rd=1 Rs2=1 Cnt=2 (Rs1 set to 3 to show it is ignored)
    applyStimulus(CMD_LOADI, ALU_ADD, 2'd1, 2'd0, 2'd0, 4'h3, 4'h0, 0);
    applyStimulus(CMD_REP, ALU_ADD, 2'd1, 2'd3, 2'd1, 4'h0, 4'h2, 0);
    checkOutput("repSetupWE", 16'(sWE), 16'h0);
    checkOutput("repWrites", 16'(nWrites), 16'h2);
    checkOutput("repLat", 16'(lat), 16'h4);
    checkOutput("repR1", 16'(rf[1]), 16'hC);
    checkOutput("repFlag", 16'(oFlag), 16'hA);

    // REP Cnt=0 and NOP: no writes, 2-cycle latency
    applyStimulus(CMD_REP, ALU_ADD, 2'd1, 2'd0, 2'd1, 4'h0, 4'h0, 0);
    checkOutput("rep0Writes", 16'(nWrites), 16'h0);
    checkOutput("rep0Lat", 16'(lat), 16'h2);
    checkOutput("rep0R1", 16'(rf[1]), 16'hC);
    applyStimulus(CMD_NOP, ALU_ADD, 2'd1, 2'd0, 2'd0, 4'h7, 4'h0, 0);
    checkOutput("nopWrites", 16'(nWrites), 16'h0);
    checkOutput("nopLat", 16'(lat), 16'h2);
    checkOutput("nopFlag", 16'(oFlag), 16'hA);
    checkOutput("busyIgnoredR0", 16'(rf[0]), 16'h0);

    // REP ADD Rd=1 Rs2=2 Cnt=10 with abort in the 3rd REP cycle
    applyStimulus(CMD_LOADI, ALU_ADD, 2'd1, 2'd0, 2'd0, 4'h0, 4'h0, 0);
    applyStimulus(CMD_LOADI, ALU_ADD, 2'd2, 2'd0, 2'd0, 4'h1, 4'h0, 0);
    applyStimulus(CMD_REP, ALU_ADD, 2'd1, 2'd0, 2'd2, 4'h0, 4'hA, 3);
    checkOutput("abortWrites", 16'(nWrites), 16'h3);
    checkOutput("abortLat", 16'(lat), 16'h5);
    checkOutput("abortR1", 16'(rf[1]), 16'h3);
    checkOutput("abortFlag", 16'(oFlag), 16'h0);

    // Async reset in the middle of a REP run
    @(negedge Clk);
    bus.iCmdValid = 1'b1;
    bus.iCmdKind = CMD_REP; bus.iCmdOp = ALU_ADD; bus.iCmdRd = 2'd1;
    bus.iCmdRs1 = 2'd0; bus.iCmdRs2 = 2'd2; bus.iCmdImm = 4'h0; bus.iCmdCnt = 4'hA;
    @(posedge Clk);
    @(negedge Clk);
    bus.iCmdValid = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    checkOutput("midRepWE", 16'(oWE), 16'h1);
    #1 Rst_n = 1'b0;
    #1;
    checkOutput("midRstWE", 16'(oWE), 16'h0);
    checkOutput("midRstBusy", 16'(oBusy), 16'h0);
    checkOutput("midRstDone", 16'(oDone), 16'h0);
    checkOutput("midRstFlag", 16'(oFlag), 16'h0);
    @(posedge Clk);
    @(negedge Clk);
    checkOutput("midRstR1", 16'(rf[1]), 16'h4);
    Rst_n = 1'b1;
    #1 checkOutput("postRstReady", 16'(bus.oCmdReady), 16'h1);
    applyStimulus(CMD_LOADI, ALU_ADD, 2'd3, 2'd0, 2'd0, 4'h5, 4'h0, 0);
    checkOutput("postRstLat", 16'(lat), 16'h2);
    checkOutput("postRstR3", 16'(rf[3]), 16'h5);
    checkOutput("postRstR1", 16'(rf[1]), 16'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/datapath_seq.md
Name: datapath_seq

Overview:
- Command-driven micro-sequencer for the 4-entry register file + ALU datapath.
- Accepts one command at a time over a valid/ready handshake and issues the regfile and ALU control signals: write enable, write/read addresses, write-data mux select, immediate, ALU op.
- Supports single-cycle LOADI and ALU commands, plus a multi-cycle REP command that applies an ALU op repeatedly to a destination register.
- Latches the ALU flags of the last committed write.

Parameters:
N, 4, data width (ALU / regfile word)
AW, 2, register address width
CW, 4, REP count width

Ports:
Clk  input  1  system clock, rising edge
Rst_n  input  1  asynchronous active-low reset
iCmdValid  input  1  command valid
oCmdReady  output  1  command accepted when iCmdValid & oCmdReady at a rising Clk edge
iCmdKind  input  2  defs::t_cmd_kind: LOADI=0, ALU=1, REP=2, NOP=3
iCmdOp  input  4  ALU opcode (defs ALU op encoding)
iCmdRd  input  AW  destination register
iCmdRs1  input  AW  source 1 (ignored for REP; Rd is used)
iCmdRs2  input  AW  source 2
iCmdImm  input  N  immediate for LOADI
iCmdCnt  input  CW  REP iteration count
iAbort  input  1  synchronous abort request for REP
iFlag  input  4  defs::t_flag from ALU: {sign, zero, overflow, carryOut}
oWE  output  1  regfile write enable
oWA  output  AW  regfile write address
oRA1  output  AW  regfile read address 1
oRA2  output  AW  regfile read address 2
oYSel  output  1  write-data mux: 1 = immediate, 0 = ALU result
oImm  output  N  immediate to write-data mux
oALUop  output  4  ALU opcode
oFlag  output  4  flags latched at the last ALU-sourced write
oBusy  output  1  high whenever state != IDLE
oDone  output  1  one-cycle pulse on command completion

Behaviour:
- Reset (Rst_n=0, async): state=IDLE, command registers=0, oFlag=0, oDone=0, oWE=0. All control outputs are 0 during and after reset.
- States: IDLE, EXEC, REP, DONE.
- IDLE: oCmdReady=1, oWE=0. On accept, latch all command fields, load iter=iCmdCnt, go to EXEC.
- Command fields are captured only on accept; input changes while busy are ignored. oCmdReady=0 in every state except IDLE.
- Control outputs are Moore, derived from state and latched fields only.
- EXEC, by kind:
  - LOADI: oWE=1, oWA=Rd, oYSel=1, oImm=Imm. Next state DONE. oFlag unchanged.
  - ALU: oWE=1, oWA=Rd, oRA1=Rs1, oRA2=Rs2, oYSel=0, oALUop=Op. Latch oFlag<=iFlag at the edge. Next state DONE.
  - NOP: oWE=0. Next state DONE.
  - REP with iter=0: oWE=0. Next state DONE.
  - REP with iter>0: go to REP with no write in EXEC (one setup cycle).
- REP: oWE=1, oWA=Rd, oRA1=Rd, oRA2=Rs2, oYSel=0, oALUop=Op. At each edge: iter<=iter-1 and oFlag<=iFlag. When iter==1 or iAbort=1, go to DONE after that edge's write. The write in the abort cycle still commits.
- DONE: oDone=1 for exactly one cycle, oWE=0. Next state IDLE.
- Latency from accept edge to oDone high:
  - LOADI / ALU / NOP: 2 cycles.
  - REP with count C>0: C+2 cycles.
  - Back-to-back commands: a new accept is possible in the cycle after DONE. Peak throughput is one command per 3 cycles.
- Rd==Rs2 in REP is legal: the register value feeds back each iteration.
- iCmdCnt is unsigned. Max REP = 2^CW-1 iterations, with no wrap of iter.
- iAbort outside REP is ignored.
- Reset mid-REP: iteration stops immediately and no further writes occur. Register contents are whatever was committed before reset.

Decomposition:
- Package defs gains typedef enum t_cmd_kind {LOADI, ALU, REP, NOP}, typedef enum t_seq_state {IDLE, EXEC, REP, DONE}, and a typedef struct packed t_cmd {kind, op, rd, rs1, rs2, imm, cnt}. It reuses the existing t_flag and ALU opcode constants.
- One sub-module, seq_ctrl_decode: combinational mapping of {state, latched t_cmd} to {oWE, oWA, oRA1, oRA2, oYSel, oImm, oALUop}.
- The FSM, iteration counter and flag register live in datapath_seq.
- Bench instantiates datapath_seq with RegFile and ALU at N=4.

Test Plan:
- Reset then LOADI Rd=1 Imm=3 -> oWE=1 for exactly one cycle with oWA=1, oYSel=1; R1=3; oDone at accept+2; oFlag stays 0.
- LOADI R2=9, then ALU ADD Rd=3 Rs1=2 Rs2=2 -> R3=2 (4'h2); oFlag.carryOut=1 and overflow=1.
- LOADI R1=3, then REP ADD Rd=1 Rs2=1 Cnt=2 -> writes 6 then 12; R1=4'hC; exactly 2 write cycles; oDone at accept+4; oFlag.sign=1.
- REP Cnt=0 -> no write cycle, oDone at accept+2. NOP -> same timing, registers unchanged.
- REP ADD Rd=1 Rs2=2 (R2=1) Cnt=10 with iAbort pulsed during the 3rd REP cycle -> exactly 3 increments committed; oDone in the following cycle.
- Rst_n low mid-REP (async, between edges) -> oWE/oBusy/oDone drop to 0 immediately; oCmdReady=1 once Rst_n deasserts; the next command executes normally.
